// File: rtl/tsm_sbox_sequencer_if.sv
// Handshake and datapath bundle between the masked S-box sequencer and its
// surroundings. The master side is the upstream/datapath/sink environment.
interface tsm_sbox_sequencer_if #(
   parameter int SW = 8,
   parameter int RW = 16
);
   logic          in_valid;
   logic          in_ready;
   logic [SW-1:0] in_share0;
   logic [SW-1:0] in_share1;
   logic [SW-1:0] in_share2;
   logic          rnd_valid;
   logic          rnd_ready;
   logic [RW-1:0] rnd_data;
   logic [RW-1:0] rnd_out;
   logic [2:0]    stg_en;
   logic [SW-1:0] dp_share0;
   logic [SW-1:0] dp_share1;
   logic [SW-1:0] dp_share2;
   logic [SW-1:0] dp_res0;
   logic [SW-1:0] dp_res1;
   logic [SW-1:0] dp_res2;
   logic          out_valid;
   logic          out_ready;
   logic [SW-1:0] out_share0;
   logic [SW-1:0] out_share1;
   logic [SW-1:0] out_share2;
   logic          busy;
   logic [15:0]   op_count;

   modport slave (
      input  in_valid, in_share0, in_share1, in_share2,
      input  rnd_valid, rnd_data, dp_res0, dp_res1, dp_res2, out_ready,
      output in_ready, rnd_ready, rnd_out, stg_en,
      output dp_share0, dp_share1, dp_share2,
      output out_valid, out_share0, out_share1, out_share2, busy, op_count
   );

   modport master (
      output in_valid, in_share0, in_share1, in_share2,
      output rnd_valid, rnd_data, dp_res0, dp_res1, dp_res2, out_ready,
      input  in_ready, rnd_ready, rnd_out, stg_en,
      input  dp_share0, dp_share1, dp_share2,
      input  out_valid, out_share0, out_share1, out_share2, busy, op_count
   );
endinterface

// File: rtl/tsm_sbox_sequencer.sv
// Sequencer for a three-stage, three-share masked S-box datapath: fetches one
// fresh randomness word per stage, pulses the stage enable, then hands out the result.
module tsm_sbox_sequencer #(
   parameter int SW = 8,
   parameter int RW = 16
) (
   input logic                 clk,
   input logic                 rst_n,
   tsm_sbox_sequencer_if.slave bus
);
   typedef enum logic [3:0] {IDLE, R1, E1, R2, E2, R3, E3, CAP, OUT} state_t;

   state_t        state_q, state_d;
   logic          live_q;
   logic [2:0]    stg_q;
   logic [RW-1:0] rnd_q;
   logic [15:0]   cnt_q;
   logic [SW-1:0] in_sh  [3];
   logic [SW-1:0] res_sh [3];
   logic [SW-1:0] dp_q   [3];
   logic [SW-1:0] out_q  [3];
   logic          rnd_wait, accept, rnd_hs, out_hs;

   assign rnd_wait = (state_q == R1) || (state_q == R2) || (state_q == R3);
   assign accept   = bus.in_ready && bus.in_valid;
   assign rnd_hs   = rnd_wait && bus.rnd_valid;
   assign out_hs   = (state_q == OUT) && bus.out_ready;

   // live_q keeps in_ready low until the first edge after reset release
   assign bus.in_ready  = (state_q == IDLE) && live_q;
   assign bus.rnd_ready = rnd_wait;
   assign bus.busy      = (state_q != IDLE);
   assign bus.out_valid = (state_q == OUT);
   assign bus.stg_en    = stg_q;
   assign bus.rnd_out   = rnd_q;
   assign bus.op_count  = cnt_q;

   assign in_sh[0]  = bus.in_share0;
   assign in_sh[1]  = bus.in_share1;
   assign in_sh[2]  = bus.in_share2;
   assign res_sh[0] = bus.dp_res0;
   assign res_sh[1] = bus.dp_res1;
   assign res_sh[2] = bus.dp_res2;

   assign bus.dp_share0  = dp_q[0];
   assign bus.dp_share1  = dp_q[1];
   assign bus.dp_share2  = dp_q[2];
   assign bus.out_share0 = out_q[0];
   assign bus.out_share1 = out_q[1];
   assign bus.out_share2 = out_q[2];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = R1;
         R1:      if (bus.rnd_valid) state_d = E1;
         E1:      state_d = R2;
         R2:      if (bus.rnd_valid) state_d = E2;
         E2:      state_d = R3;
         R3:      if (bus.rnd_valid) state_d = E3;
         E3:      state_d = CAP;
         CAP:     state_d = OUT;
         OUT:     if (bus.out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Stage enables come straight from flops, decoded from the next state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         live_q <= 1'b0;
         stg_q  <= '0;
         rnd_q  <= '0;
         cnt_q  <= '0;
      end else begin
         live_q <= 1'b1;
         stg_q  <= {state_d == E3, state_d == E2, state_d == E1};
         if (rnd_hs)      rnd_q <= bus.rnd_data;
         else if (out_hs) rnd_q <= '0;
         if (out_hs)      cnt_q <= cnt_q + 16'd1;
      end
   end

   // One independent register path per share index; shares never meet here
   for (genvar g = 0; g < 3; g++) begin : g_share
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            dp_q[g]  <= '0;
            out_q[g] <= '0;
         end else begin
            if (accept) dp_q[g] <= in_sh[g];
            if (state_q == CAP) out_q[g] <= res_sh[g];
            else if (out_hs)    out_q[g] <= '0;
         end
      end
   end
endmodule

// File: tb/tb_tsm_sbox_sequencer.sv
// Self-checking bench: a timeline reference model watches every cycle while
// table, directed and random operations are driven through the sequencer.
module tb_tsm_sbox_sequencer;
   localparam int SW = 8;
   localparam int RW = 16;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   tsm_sbox_sequencer_if #(.SW(SW), .RW(RW)) bus ();
   tsm_sbox_sequencer #(.SW(SW), .RW(RW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // free-running randomness and datapath results
   always @(posedge clk) begin
      #1;
      bus.rnd_data = RW'($urandom);
      bus.dp_res0  = SW'($urandom);
      bus.dp_res1  = SW'($urandom);
      bus.dp_res2  = SW'($urandom);
   end

   logic seen;
   always @(posedge clk or negedge rst_n)
      if (!rst_n) seen <= 1'b0;
      else        seen <= 1'b1;

   // Reference model: an operation is a timeline of events (accept cycle,
   // three randomness handshakes); every output follows from those times.
   bit            inflight = 0;
   bit            forcing = 0;
   int            cyc = 0, acc_c = 0, nhs = 0;
   int            hs [3];
   logic [RW-1:0] w [3];
   logic [SW-1:0] mcap [3];
   logic [SW-1:0] mdp [3];
   logic [15:0]   opc = 16'd0;

   always @(negedge clk) begin : mon
      logic e_ir, e_rr, e_ov;
      logic [2:0] e_stg;
      logic [RW-1:0] e_ro;
      if (!rst_n) begin
         chk("rst_in_ready", 32'(bus.in_ready), 0);
         chk("rst_rnd_ready", 32'(bus.rnd_ready), 0);
         chk("rst_busy", 32'(bus.busy), 0);
         chk("rst_out_valid", 32'(bus.out_valid), 0);
         chk("rst_stg_en", 32'(bus.stg_en), 0);
         chk("rst_rnd_out", 32'(bus.rnd_out), 0);
         chk("rst_dp_share", 32'({bus.dp_share2, bus.dp_share1, bus.dp_share0}), 0);
         chk("rst_out_share", 32'({bus.out_share2, bus.out_share1, bus.out_share0}), 0);
         chk("rst_op_count", 32'(bus.op_count), 0);
         inflight = 0; nhs = 0; opc = 16'd0;
         for (int i = 0; i < 3; i++) begin mdp[i] = '0; mcap[i] = '0; end
      end else begin
         if (forcing) opc = 16'hFFFF;
         e_ir = !inflight && seen;
         e_rr = inflight && nhs < 3 && cyc >= ((nhs == 0) ? acc_c + 1 : hs[nhs-1] + 2);
         e_stg = 3'b000;
         for (int k = 0; k < 3; k++) if (k < nhs && cyc == hs[k] + 1) e_stg[k] = 1'b1;
         e_ro = (inflight && nhs > 0) ? w[nhs-1] : '0;
         e_ov = inflight && nhs == 3 && cyc >= hs[2] + 3;
         chk("in_ready", 32'(bus.in_ready), 32'(e_ir));
         chk("rnd_ready", 32'(bus.rnd_ready), 32'(e_rr));
         chk("busy", 32'(bus.busy), 32'(inflight));
         chk("stg_en", 32'(bus.stg_en), 32'(e_stg));
         chk("rnd_out", 32'(bus.rnd_out), 32'(e_ro));
         chk("out_valid", 32'(bus.out_valid), 32'(e_ov));
         chk("out_share", 32'({bus.out_share2, bus.out_share1, bus.out_share0}),
             e_ov ? 32'({mcap[2], mcap[1], mcap[0]}) : 32'd0);
         chk("dp_share", 32'({bus.dp_share2, bus.dp_share1, bus.dp_share0}),
             32'({mdp[2], mdp[1], mdp[0]}));
         chk("op_count", 32'(bus.op_count), 32'(opc));
         if (e_ir && bus.in_valid) begin
            inflight = 1; acc_c = cyc; nhs = 0;
            mdp[0] = bus.in_share0; mdp[1] = bus.in_share1; mdp[2] = bus.in_share2;
         end
         if (e_rr && bus.rnd_valid) begin
            hs[nhs] = cyc; w[nhs] = bus.rnd_data; nhs++;
         end
         if (inflight && nhs == 3 && cyc == hs[2] + 2) begin
            mcap[0] = bus.dp_res0; mcap[1] = bus.dp_res1; mcap[2] = bus.dp_res2;
         end
         if (e_ov && bus.out_ready) begin
            inflight = 0; opc = opc + 16'd1;
         end
      end
      cyc++;
   end

   task automatic idle_cycles(input int n, input bit noise);
      repeat (n) begin
         @(posedge clk); #1;
         bus.in_valid  = 1'b0;
         bus.rnd_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
         bus.out_ready = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      end
   endtask

   // One operation: stall randomness in R2 for r2stall cycles, hold out_ready
   // low for ostall out_valid cycles, optionally pulse in_valid at step pulse_t.
   task automatic run_op(input logic [SW-1:0] s0, s1, s2, input int r2stall,
                         input int ostall, input int pulse_t, output int lat);
      int t, h, sl, ol;
      bit done;
      lat = -1; h = 0; sl = r2stall; ol = ostall; done = 0; t = 0;
      @(posedge clk); #1;
      bus.in_valid = 1'b1;
      bus.in_share0 = s0; bus.in_share1 = s1; bus.in_share2 = s2;
      bus.rnd_valid = 1'b1;
      bus.out_ready = (ol <= 0);
      @(negedge clk);
      chk("accept_ready", 32'(bus.in_ready), 1);
      while (!done && t < 80) begin
         @(posedge clk); #1;
         t++;
         bus.in_valid = (t == pulse_t);
         if (t == pulse_t) begin
            bus.in_share0 = 8'hFF; bus.in_share1 = 8'hFF; bus.in_share2 = 8'hFF;
         end
         bus.rnd_valid = !(h == 1 && sl > 0);
         bus.out_ready = (ol <= 0);
         @(negedge clk);
         if (bus.out_valid && lat < 0) lat = t;
         if (bus.rnd_ready && bus.rnd_valid) h++;
         else if (bus.rnd_ready && sl > 0) sl--;
         if (bus.out_valid && bus.out_ready) done = 1;
         else if (bus.out_valid) ol--;
      end
      chk("op_completes", 32'(done), 1);
      @(posedge clk); #1;
      bus.in_valid = 1'b0; bus.rnd_valid = 1'b0; bus.out_ready = 1'b0;
   endtask

   typedef struct {
      logic [SW-1:0] s0, s1, s2;
      int r2stall, ostall, pulse_t, exp_lat;
   } vec_t;

   initial begin : wdog
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin : stim
      vec_t tbl[5];
      int lat, exp_cnt;
      tbl[0] = '{8'h11, 8'h22, 8'h33, 0, 0, 0, 8};
      tbl[1] = '{8'hA5, 8'h5A, 8'hC3, 5, 0, 0, 13};
      tbl[2] = '{8'h01, 8'h02, 8'h03, 0, 4, 0, 8};
      tbl[3] = '{8'hDE, 8'hAD, 8'hBE, 0, 0, 2, 8};
      tbl[4] = '{8'hFF, 8'h00, 8'h80, 2, 3, 5, 10};

      bus.in_valid = 1'b0; bus.rnd_valid = 1'b0; bus.out_ready = 1'b0;
      bus.in_share0 = '0; bus.in_share1 = '0; bus.in_share2 = '0;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      exp_cnt = 0;
      foreach (tbl[i]) begin
         run_op(tbl[i].s0, tbl[i].s1, tbl[i].s2, tbl[i].r2stall, tbl[i].ostall,
                tbl[i].pulse_t, lat);
         exp_cnt++;
         chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(tbl[i].exp_lat));
         chk($sformatf("vec%0d_op_count", i), 32'(bus.op_count), 32'(exp_cnt));
      end

      // reset while E2 is active: everything drops at once
      @(posedge clk); #1;
      bus.in_valid = 1'b1; bus.in_share0 = 8'h12; bus.in_share1 = 8'h34; bus.in_share2 = 8'h56;
      bus.rnd_valid = 1'b1; bus.out_ready = 1'b1;
      @(posedge clk); #1 bus.in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1 chk("e2_stg_en", 32'(bus.stg_en), 32'h2);
      rst_n = 1'b0;
      #1;
      chk("midrst_stg_en", 32'(bus.stg_en), 0);
      chk("midrst_busy", 32'(bus.busy), 0);
      chk("midrst_rnd_out", 32'(bus.rnd_out), 0);
      chk("midrst_dp_share", 32'({bus.dp_share2, bus.dp_share1, bus.dp_share0}), 0);
      chk("midrst_in_ready", 32'(bus.in_ready), 0);
      chk("midrst_op_count", 32'(bus.op_count), 0);
      @(posedge clk); #1;
      rst_n = 1'b1; bus.rnd_valid = 1'b0; bus.out_ready = 1'b0;
      run_op(8'h21, 8'h43, 8'h65, 0, 0, 0, lat);
      chk("post_rst_latency", 32'(lat), 8);
      chk("post_rst_op_count", 32'(bus.op_count), 1);

      // wrap of the completion counter
      @(posedge clk); #1;
      force dut.cnt_q = 16'hFFFF;
      forcing = 1;
      @(negedge clk); #1;
      release dut.cnt_q;
      forcing = 0;
      run_op(8'h0F, 8'hF0, 8'h3C, 1, 1, 0, lat);
      chk("wrap_op_count", 32'(bus.op_count), 0);

      // random operations with idle-time noise on rnd_valid/out_ready
      for (int i = 0; i < 30; i++) begin
         int r2s, os, pt;
         r2s = $urandom_range(0, 3);
         os  = $urandom_range(0, 3);
         pt  = $urandom_range(0, 6);
         idle_cycles($urandom_range(0, 3), 1'b1);
         run_op(SW'($urandom), SW'($urandom), SW'($urandom), r2s, os, pt, lat);
         chk($sformatf("rand%0d_latency", i), 32'(lat), 32'(8 + r2s));
      end
      chk("final_op_count", 32'(bus.op_count), 30);

      idle_cycles(2, 1'b0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
